// File: rtl/ex_mem_skid_buffer_if.sv
// ex_mem_skid_buffer_if: execute -> memory handshake bundle.
// in_* from execute, out_* to memory; slave = buffer, master = driver.
interface ex_mem_skid_buffer_if #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_alu_out;
  logic              in_branch_enable;
  logic [DATA_W-1:0] in_pc;
  logic [DATA_W-1:0] in_store_data;
  logic [RD_W-1:0]   in_rd;
  logic              in_wb_en;
  logic              in_mem_read;
  logic              in_mem_write;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_alu_out;
  logic              out_branch_enable;
  logic [DATA_W-1:0] out_pc;
  logic [DATA_W-1:0] out_store_data;
  logic [RD_W-1:0]   out_rd;
  logic              out_wb_en;
  logic              out_mem_read;
  logic              out_mem_write;

  modport slave (
    input  in_valid, in_alu_out, in_branch_enable,
    input  in_pc, in_store_data, in_rd,
    input  in_wb_en, in_mem_read, in_mem_write,
    output in_ready,
    output out_valid, out_alu_out, out_branch_enable,
    output out_pc, out_store_data, out_rd,
    output out_wb_en, out_mem_read, out_mem_write,
    input  out_ready
  );

  modport master (
    output in_valid, in_alu_out, in_branch_enable,
    output in_pc, in_store_data, in_rd,
    output in_wb_en, in_mem_read, in_mem_write,
    input  in_ready,
    input  out_valid, out_alu_out, out_branch_enable,
    input  out_pc, out_store_data, out_rd,
    input  out_wb_en, out_mem_read, out_mem_write,
    output out_ready
  );
endinterface

// File: rtl/ex_mem_skid_buffer.sv
// ex_mem_skid_buffer: 2-entry EX->MEM skid buffer (head + skid).
// Ports: clk, reset (sync, high), flush, bus (slave), occupancy.
module ex_mem_skid_buffer #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  ex_mem_skid_buffer_if.slave  bus,
  output logic [1:0]           occupancy
);

  typedef struct packed {
    logic [DATA_W-1:0] alu_out;
    logic              branch_enable;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] store_data;
    logic [RD_W-1:0]   rd;
    logic              wb_en;
    logic              mem_read;
    logic              mem_write;
  } ent_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;
  ent_t   head;
  ent_t   skid;
  ent_t   in_ent;
  logic   acc;
  logic   pop;
  logic   head_ld_in;
  logic   head_ld_skid;
  logic   skid_ld;

  // writes to x0 are dropped here so MEM/WB never sees them
  always_comb begin
    in_ent               = '0;
    in_ent.alu_out       = bus.in_alu_out;
    in_ent.branch_enable = bus.in_branch_enable;
    in_ent.pc            = bus.in_pc;
    in_ent.store_data    = bus.in_store_data;
    in_ent.rd            = bus.in_rd;
    in_ent.wb_en         = bus.in_wb_en &&
                           (bus.in_rd != '0);
    in_ent.mem_read      = bus.in_mem_read;
    in_ent.mem_write     = bus.in_mem_write;
  end

  // registered state only: no path from out_ready
  assign bus.in_ready  = !reset && (state != FULL);
  assign bus.out_valid = (state != EMPTY);

  assign acc = bus.in_valid && bus.in_ready;
  assign pop = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      unique case (state)
        EMPTY: if (acc) state_nxt = ONE;
        ONE: begin
          if (acc && !pop)      state_nxt = FULL;
          else if (!acc && pop) state_nxt = EMPTY;
        end
        FULL:  if (pop) state_nxt = ONE;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // flush suppresses all loads so a dead head keeps its payload
  always_comb begin
    occupancy    = state;
    head_ld_in   = 1'b0;
    head_ld_skid = 1'b0;
    skid_ld      = 1'b0;
    if (!flush) begin
      head_ld_in   = acc &&
                     ((state == EMPTY) ||
                      ((state == ONE) && pop));
      skid_ld      = acc && (state == ONE) && !pop;
      head_ld_skid = (state == FULL) && pop;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head <= '0;
      skid <= '0;
    end else begin
      if (head_ld_in)        head <= in_ent;
      else if (head_ld_skid) head <= skid;
      if (skid_ld)           skid <= in_ent;
    end
  end

  assign bus.out_alu_out       = head.alu_out;
  assign bus.out_branch_enable = head.branch_enable;
  assign bus.out_pc            = head.pc;
  assign bus.out_store_data    = head.store_data;
  assign bus.out_rd            = head.rd;
  assign bus.out_wb_en         = head.wb_en;
  assign bus.out_mem_read      = head.mem_read;
  assign bus.out_mem_write     = head.mem_write;

endmodule
